concat_unpacker: RTL and testbench
==================================

Name: concat_unpacker

Overview:
- Inverse of the field-concatenation path: accepts one packed word {a,b,c} (field a in the MSBs) and emits its fields one per cycle, MSB field first, over a valid/ready stream.
- Detects replicated words ({NUM_FIELDS{x}}) and flags them; optionally collapses them to a single emitted field.
- Sits between a packed-word producer and any nibble-wide consumer.

Parameters:
- FIELD_W, 4, width of one field in bits.
- NUM_FIELDS, 3, fields per packed word (2..8); packed width W = FIELD_W*NUM_FIELDS (12 by default).
- COLLAPSE_REP, 0, when 1 a replicated word is emitted as one beat instead of NUM_FIELDS beats.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  packed word present.
- in_ready  out  1  unpacker can accept a word this cycle.
- in_word  in  W  packed word, field 0 = in_word[W-1 -: FIELD_W].
- out_valid  out  1  field beat present.
- out_ready  in  1  consumer accepts beat.
- out_field  out  FIELD_W  current field value.
- out_idx  out  3  index of current field (0 = MSB field).
- out_last  out  1  current beat is the final beat of its word.
- out_rep  out  1  word of current beat is replicated (all fields equal); constant across a word's beats.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clock edge): state=IDLE, out_valid=0, out_field=0, out_idx=0, out_last=0, out_rep=0, holding register=0. in_ready=1 from the first cycle after reset release.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - EMIT: out_valid=1.
- Input acceptance: a word is taken when in_valid && in_ready, and is captured into a holding register.
  - rep = (all fields equal), computed combinationally at capture and registered.
  - Move to EMIT with idx=0.
- Output timing: out_field is driven from the holding register, field idx.
  - Latency: first beat is valid the cycle after acceptance.
- Beat advance: on out_valid && out_ready.
  - If not last: idx++.
  - If last and in_valid: capture the new word, idx=0, stay in EMIT. This is back-to-back operation with no bubble.
  - If last and !in_valid: go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_last && out_ready). This is combinational from out_ready; no combinational path exists from in_valid to out_*.
- out_last:
  - COLLAPSE_REP=0: out_last = (idx==NUM_FIELDS-1).
  - COLLAPSE_REP=1: out_last = rep || (idx==NUM_FIELDS-1). A replicated word produces exactly one beat, with idx=0, out_rep=1, out_last=1.
- Stall: while out_valid && !out_ready, out_field, out_idx, out_last and out_rep are held stable and no input is accepted.
- Replication all-zero/all-ones: 12'h000 and 12'hFFF are replicated (out_rep=1).
- Reset mid-word: abandons any remaining beats; no partial word resumes after reset.
- Unused upper bits of out_idx (when NUM_FIELDS<8) are 0.

Test Plan:
- Reset then single word: in_word=12'hF5E, out_ready=1.
  - Expect beats F,5,E with idx 0,1,2; out_last only on E; out_rep=0.
  - in_ready low for exactly 2 cycles after acceptance.
- Back-to-back: words 12'h123 then 12'hA0B held valid, out_ready=1.
  - Expect 1,2,3,A,0,B on 6 consecutive cycles with no bubble.
  - Second word accepted on the cycle beat 3 is consumed.
- Backpressure: word 12'hABC, out_ready toggled 1,0,0,1,1.
  - Beat B held stable through both stall cycles.
  - No input accepted until C is consumed.
- Replication, COLLAPSE_REP=0: word 12'hEEE.
  - Expect 3 beats E with out_rep=1 on all.
  - Word 12'hEEF gives out_rep=0.
- Replication, COLLAPSE_REP=1: words 12'h777 then 12'h000 then 12'h7A7.
  - Expect beats 7(last,rep), 0(last,rep), then 7,A,7 with rep=0.
- Reset mid-word: word 12'h456, assert rst_n=0 after beat 4 is consumed.
  - Next cycle out_valid=0 and all outputs 0.
  - After release, new word 12'h9C1 emits 9,C,1 with idx starting at 0.

Source files
------------

// File: rtl/concat_unpacker.sv
// ============================================================================
// Module   : concat_unpacker
// Brief    : Splits a packed {f0,f1,...} word into MSB-first field beats on a
//            valid/ready stream, flagging (and optionally collapsing) words
//            whose fields are all equal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module concat_unpacker #(
  parameter int FIELD_W      = 4,
  parameter int NUM_FIELDS   = 3,
  parameter int COLLAPSE_REP = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FIELD_W*NUM_FIELDS-1:0] in_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W-1:0]            out_field,
  output logic [2:0]                    out_idx,
  output logic                          out_last,
  output logic                          out_rep
);

  localparam int         W        = FIELD_W * NUM_FIELDS;
  localparam logic [2:0] LAST_IDX = 3'(NUM_FIELDS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [W-1:0]          word_q, word_d;
  logic [2:0]            idx_q, idx_d;
  logic                  rep_q, rep_d;

  logic [NUM_FIELDS-1:0] in_eq;
  logic                  in_rep;
  logic [FIELD_W-1:0]    cur_field;
  logic                  is_last_idx;
  logic                  beat_last;
  logic                  emit;
  logic                  beat_fire;
  logic                  accept;

  // Replication test: every field compared against the MSB field.
  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    assign in_eq[g] = (in_word[W-1-g*FIELD_W -: FIELD_W] == in_word[W-1 -: FIELD_W]);
  end

  assign in_rep = &in_eq;

  always_comb begin
    cur_field = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_field = word_q[W-1-i*FIELD_W -: FIELD_W];
      end
    end
  end

  assign is_last_idx = (idx_q == LAST_IDX);

  if (COLLAPSE_REP != 0) begin : g_collapse
    assign beat_last = rep_q || is_last_idx;
  end else begin : g_no_collapse
    assign beat_last = is_last_idx;
  end

  assign emit      = (state_q == S_EMIT);
  assign beat_fire = emit && out_ready;
  // Ready only depends on out_ready and state, never on in_valid.
  assign in_ready  = !emit || (beat_last && out_ready);
  assign accept    = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    rep_d   = rep_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (beat_fire && beat_last && !in_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      word_d = in_word;
      rep_d  = in_rep;
      idx_d  = '0;
    end else if (beat_fire) begin
      idx_d = beat_last ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Outputs
  always_comb begin
    out_valid = emit;
    out_field = cur_field;
    out_idx   = idx_q;
    out_last  = emit && beat_last;
    out_rep   = emit && rep_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_concat_unpacker.sv
// ============================================================================
// Module   : tb_concat_unpacker
// Brief    : Self-checking bench for concat_unpacker, both collapse modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_concat_unpacker;

  localparam int FW = 4;
  localparam int NF = 3;

  typedef struct packed {
    logic [FW-1:0] f;
    logic [2:0]    idx;
    logic          last;
    logic          rep;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [11:0]   in_word   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [FW-1:0] out_field [2];
  logic [2:0]    out_idx   [2];
  logic          out_last  [2];
  logic          out_rep   [2];

  int tests = 0;
  int fails = 0;

  beat_t q     [2][$];
  beat_t log_b [2][$];
  beat_t exp_log[$];
  logic  prev_rst_n = 1'b1;

  concat_unpacker #(.FIELD_W(FW), .NUM_FIELDS(NF), .COLLAPSE_REP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_word(in_word[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_field(out_field[0]),
    .out_idx(out_idx[0]), .out_last(out_last[0]), .out_rep(out_rep[0])
  );

  concat_unpacker #(.FIELD_W(FW), .NUM_FIELDS(NF), .COLLAPSE_REP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_word(in_word[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_field(out_field[1]),
    .out_idx(out_idx[1]), .out_last(out_last[1]), .out_rep(out_rep[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t b(input logic [3:0] f, input int idx, input bit last, input bit rep);
    beat_t r;
    r.f    = f;
    r.idx  = 3'(idx);
    r.last = last;
    r.rep  = rep;
    return r;
  endfunction

  // Reference: the beats a word must produce, from field arithmetic alone.
  task automatic push_word(input int s, input logic [11:0] w);
    logic [FW-1:0] f [NF];
    bit            rep;
    rep = 1'b1;
    for (int i = 0; i < NF; i++) begin
      f[i] = FW'((w >> ((NF - 1 - i) * FW)) & 12'hF);
      if (f[i] != f[0]) rep = 1'b0;
    end
    if (s == 1 && rep) begin
      q[s].push_back(b(f[0], 0, 1'b1, 1'b1));
    end else begin
      for (int i = 0; i < NF; i++) q[s].push_back(b(f[i], i, i == NF - 1, rep));
    end
  endtask

  // Compare process: inputs change just after posedge, so negedge sees what
  // the next edge will act on.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      bit ev;
      ev = (q[s].size() != 0);
      if (rst_n) begin
        chk($sformatf("out_valid[%0d]", s), 32'(out_valid[s]), 32'(ev));
        if (ev && out_valid[s]) begin
          chk($sformatf("out_field[%0d]", s), 32'(out_field[s]), 32'(q[s][0].f));
          chk($sformatf("out_idx[%0d]", s),   32'(out_idx[s]),   32'(q[s][0].idx));
          chk($sformatf("out_last[%0d]", s),  32'(out_last[s]),  32'(q[s][0].last));
          chk($sformatf("out_rep[%0d]", s),   32'(out_rep[s]),   32'(q[s][0].rep));
        end
        chk($sformatf("in_ready[%0d]", s), 32'(in_ready[s]),
            32'(!ev || (q[s][0].last && out_ready[s])));
      end
      if (!prev_rst_n) begin
        chk($sformatf("rst_outs[%0d]", s),
            {24'(out_valid[s]), out_field[s], 1'b0, out_idx[s], out_last[s], out_rep[s], 2'b0},
            32'h0);
      end
      if (!rst_n) begin
        q[s].delete();
      end else begin
        if (ev && out_valid[s] && out_ready[s]) begin
          log_b[s].push_back(b(out_field[s], int'(out_idx[s]), out_last[s], out_rep[s]));
          void'(q[s].pop_front());
        end
        if (in_valid[s] && in_ready[s]) push_word(s, in_word[s]);
      end
    end
    prev_rst_n = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic [11:0] w);
    bit ok;
    ok = 1'b0;
    in_valid[s] = 1'b1;
    in_word[s]  = w;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (in_ready[s]) ok = 1'b1;
      tick();
    end
    in_valid[s] = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int s);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (!out_valid[s]) done = 1'b1;
      else tick();
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_log(input int s, input string name);
    chk({name, "_len"}, 32'(log_b[s].size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < log_b[s].size(); i++) begin
      chk($sformatf("%s_beat%0d", name, i), 32'(log_b[s][i]), 32'(exp_log[i]));
    end
    exp_log.delete();
    log_b[s].delete();
  endtask

  initial begin
    logic [3:0] ef [6];
    logic       er [5];
    logic       rdy[5];
    logic [3:0] nib;

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      in_word[s]   = '0;
      out_ready[s] = 1'b1;
    end
    repeat (3) tick();
    chk("reset_valid", 32'(out_valid[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready[0]), 32'd1);

    // Single word F5E: in_ready low exactly two cycles after acceptance.
    send(0, 12'hF5E);
    ef[0] = 4'hF; ef[1] = 4'h5; ef[2] = 4'hE;
    er[0] = 1'b0; er[1] = 1'b0; er[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("single_field%0d", k), 32'(out_field[0]), 32'(ef[k]));
      chk($sformatf("single_ready%0d", k), 32'(in_ready[0]), 32'(er[k]));
      tick();
    end
    drain(0);
    exp_log.push_back(b(4'hF, 0, 0, 0));
    exp_log.push_back(b(4'h5, 1, 0, 0));
    exp_log.push_back(b(4'hE, 2, 1, 0));
    check_log(0, "single");

    // Back-to-back 123 then A0B with no bubble.
    in_valid[0] = 1'b1;
    in_word[0]  = 12'h123;
    tick();
    in_word[0]  = 12'hA0B;
    ef[0] = 4'h1; ef[1] = 4'h2; ef[2] = 4'h3; ef[3] = 4'hA; ef[4] = 4'h0; ef[5] = 4'hB;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("b2b_valid%0d", k), 32'(out_valid[0]), 32'd1);
      chk($sformatf("b2b_field%0d", k), 32'(out_field[0]), 32'(ef[k]));
      if (k == 2) chk("b2b_accept", 32'(in_ready[0]), 32'd1);
      tick();
      if (k == 2) in_valid[0] = 1'b0;
    end
    drain(0);
    log_b[0].delete();

    // Backpressure on ABC with a pending word that must wait for C.
    send(0, 12'hABC);
    in_valid[0] = 1'b1;
    in_word[0]  = 12'h111;
    rdy[0] = 1; rdy[1] = 0; rdy[2] = 0; rdy[3] = 1; rdy[4] = 1;
    ef[0] = 4'hA; ef[1] = 4'hB; ef[2] = 4'hB; ef[3] = 4'hB; ef[4] = 4'hC;
    er[0] = 0; er[1] = 0; er[2] = 0; er[3] = 0; er[4] = 1;
    for (int k = 0; k < 5; k++) begin
      out_ready[0] = rdy[k];
      #1;
      chk($sformatf("bp_field%0d", k), 32'(out_field[0]), 32'(ef[k]));
      chk($sformatf("bp_ready%0d", k), 32'(in_ready[0]), 32'(er[k]));
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    drain(0);
    exp_log.push_back(b(4'hA, 0, 0, 0));
    exp_log.push_back(b(4'hB, 1, 0, 0));
    exp_log.push_back(b(4'hC, 2, 1, 0));
    exp_log.push_back(b(4'h1, 0, 0, 1));
    exp_log.push_back(b(4'h1, 1, 0, 1));
    exp_log.push_back(b(4'h1, 2, 1, 1));
    check_log(0, "bp");

    // Replication without collapse.
    send(0, 12'hEEE);
    send(0, 12'hEEF);
    drain(0);
    exp_log.push_back(b(4'hE, 0, 0, 1));
    exp_log.push_back(b(4'hE, 1, 0, 1));
    exp_log.push_back(b(4'hE, 2, 1, 1));
    exp_log.push_back(b(4'hE, 0, 0, 0));
    exp_log.push_back(b(4'hE, 1, 0, 0));
    exp_log.push_back(b(4'hF, 2, 1, 0));
    check_log(0, "rep0");

    // Replication with collapse.
    send(1, 12'h777);
    send(1, 12'h000);
    send(1, 12'h7A7);
    drain(1);
    exp_log.push_back(b(4'h7, 0, 1, 1));
    exp_log.push_back(b(4'h0, 0, 1, 1));
    exp_log.push_back(b(4'h7, 0, 0, 0));
    exp_log.push_back(b(4'hA, 1, 0, 0));
    exp_log.push_back(b(4'h7, 2, 1, 0));
    check_log(1, "rep1");

    // Reset mid-word after the first beat.
    send(0, 12'h456);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_field", 32'(out_field[0]), 32'd0);
    chk("midrst_idx",   32'(out_idx[0]),   32'd0);
    exp_log.push_back(b(4'h4, 0, 0, 0));
    check_log(0, "midrst_partial");
    send(0, 12'h9C1);
    drain(0);
    exp_log.push_back(b(4'h9, 0, 0, 0));
    exp_log.push_back(b(4'hC, 1, 0, 0));
    exp_log.push_back(b(4'h1, 2, 1, 0));
    check_log(0, "midrst_new");

    // Randomized traffic against the reference queue.
    for (int s = 0; s < 2; s++) begin
      for (int cyc = 0; cyc < 1500; cyc++) begin
        rst_n        = ($urandom % 300) != 0;
        in_valid[s]  = ($urandom % 3) != 0;
        nib          = 4'($urandom);
        in_word[s]   = (($urandom % 4) == 0) ? {3{nib}} : 12'($urandom);
        out_ready[s] = ($urandom % 4) != 0;
        tick();
      end
      rst_n        = 1'b1;
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b1;
      tick();
      drain(s);
      chk($sformatf("rand_empty%0d", s), 32'(q[s].size()), 32'd0);
      log_b[s].delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
